mic_microsequencer: RTL and testbench
=====================================

// Module: mic_microsequencer
// PURPOSE
//  Microprogram sequencer for the Mic-1 datapath. Holds MPC and MIR, fetches microinstructions
//  from a sync-read control store, drives ALU/shifter/C-bus/B-bus/memory controls and
//  computes the next MPC from NEXT_ADDRESS, JAMN/JAMZ (ALU N/Z) and JMPC (MBR).
//  Stalls on memory busy. Halts on a programmed halt address.
// PARAMETERS
//  MPC_BITS     9          control store address width
//  MIR_BITS     36         microinstruction width
//  ALU_CONTROL  6          ALU function code width (F0 F1 ENA ENB INVA INC)
//  HALT_ADDR    9'h1FF     NEXT_ADDRESS value that halts when no jam bit is set
// PORTS
//  clk          in   1         system clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  cs_addr      out  MPC_BITS  control store read address (= MPC)
//  cs_data      in   MIR_BITS  control store data, valid 1 cycle after cs_addr
//  alu_n        in   1         ALU negative flag, current cycle
//  alu_z        in   1         ALU zero flag, current cycle
//  mbr          in   8         memory byte register (opcode), used by JMPC
//  mem_busy     in   1         memory cannot accept/complete an access this cycle
//  alu_control  out  ALU_CONTROL  ALU function to datapath
//  shift        out  2         shifter control {SLL8, SRA1}
//  c_sel        out  9         C-bus write enables, one-hot per register, 0 = no write
//  mem_ctl      out  3         {WRITE, READ, FETCH}
//  b_sel        out  4         B-bus source select
//  n_flag       out  1         latched N of last executed microinstruction
//  z_flag       out  1         latched Z of last executed microinstruction
//  halted       out  1         sequencer stopped at HALT_ADDR
//  uinstr_count out  32        count of executed microinstructions, wraps
// BEHAVIOUR
//  MIR fields: [35:27] NEXT_ADDRESS, [26] JMPC, [25] JAMN, [24] JAMZ, [23:22] shift,
//   [21:16] alu_control, [15:7] c_sel, [6:4] mem_ctl, [3:0] b_sel.
//  Reset (async, rst_n=0): MPC=0, MIR=0, state LOAD, all outputs 0, count 0, flags 0.
//  States: LOAD, EXEC, HALT.
//   LOAD: cs_addr=MPC; control outputs forced 0. Next edge: MIR<=cs_data, goto EXEC.
//   EXEC, mem_busy=1: stall. Control outputs forced 0; MPC, MIR, flags, count held.
//    Stay in EXEC.
//   EXEC, mem_busy=0: outputs = MIR fields (one execute cycle). Next edge:
//    n_flag<=alu_n, z_flag<=alu_z, count++ (wraps 2^32-1 -> 0), MPC<=next_mpc.
//    Goto LOAD, or HALT if halt condition.
//  next_mpc[8]   = NA[8] | (JAMN & alu_n) | (JAMZ & alu_z)
//  next_mpc[7:0] = NA[7:0] | (JMPC ? mbr : 8'h00)   (bitwise OR, no addition)
//  Halt cond: NA==HALT_ADDR and JMPC=JAMN=JAMZ=0, evaluated in a non-stalled EXEC.
//   The halting microinstruction still executes fully: outputs, flags, count.
//  HALT: halted=1, control outputs 0, all state frozen; exit only via rst_n.
//  Throughput: 2 cycles per microinstruction + 1 per stall cycle.
//  Unknown ALU codes are passed through unchanged; the ALU maps them to A.
//  rst_n asserted mid-EXEC or mid-stall: immediate return to reset values.
//   The in-flight microinstruction is discarded, count is not incremented.
//   First cs_addr after release is 0.
// TESTING
//  1. Reset release, cs_data at addr 0 = NA 0x005, alu 0x3C, c_sel 0x001 ->
//     cs_addr 0 then 5; alu_control 0x3C for exactly 1 cycle; count=1.
//  2. JAMZ=1, NA=0x010, alu_z=1 -> next cs_addr 0x110. Same with alu_z=0 -> 0x010.
//     z_flag tracks.
//  3. JMPC=1, NA=0x100, mbr=0x60 -> next cs_addr 0x160. NA=0x001, mbr=0x60 -> 0x061 (OR).
//  4. mem_ctl=READ with mem_busy high for 3 cycles in EXEC -> outputs 0 for 3 cycles,
//     then 1 execute cycle; count +1 only.
//  5. NA=0x1FF, no jams -> executes once, halted=1 next cycle, cs_addr frozen;
//     rst_n pulse -> restart at 0.
//  6. rst_n low mid-stall -> all outputs 0 asynchronously; count preset 0xFFFFFFFF
//     wraps to 0 on next execute.

Source files
------------

// File: rtl/mic_microsequencer.sv
// Mic-1 microprogram sequencer: holds MPC/MIR, fetches from a sync-read control store,
// decodes datapath controls and forms the next MPC from NEXT_ADDRESS, JAMN/JAMZ and JMPC.
module mic_microsequencer #(
  parameter int unsigned          MPC_BITS    = 9,
  parameter int unsigned          MIR_BITS    = 36,
  parameter int unsigned          ALU_CONTROL = 6,
  parameter logic [MPC_BITS-1:0]  HALT_ADDR   = 9'h1FF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [MPC_BITS-1:0]    cs_addr,
  input  logic [MIR_BITS-1:0]    cs_data,
  input  logic                   alu_n,
  input  logic                   alu_z,
  input  logic [7:0]             mbr,
  input  logic                   mem_busy,
  output logic [ALU_CONTROL-1:0] alu_control,
  output logic [1:0]             shift,
  output logic [8:0]             c_sel,
  output logic [2:0]             mem_ctl,
  output logic [3:0]             b_sel,
  output logic                   n_flag,
  output logic                   z_flag,
  output logic                   halted,
  output logic [31:0]            uinstr_count
);

  localparam int unsigned LOW_BITS = MPC_BITS - 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [MPC_BITS-1:0]   mpc_q;
  logic [MIR_BITS-1:0]   mir_q;
  logic [31:0]           count_q;
  logic                  n_q, z_q;

  logic                  mir_load;
  logic                  exec_go;
  logic [MPC_BITS-1:0]   next_mpc;
  logic                  halt_cond;

  // Microinstruction field view of MIR
  logic [MPC_BITS-1:0]    f_na;
  logic                   f_jmpc, f_jamn, f_jamz;
  logic [1:0]             f_shift;
  logic [ALU_CONTROL-1:0] f_alu;
  logic [8:0]             f_csel;
  logic [2:0]             f_mem;
  logic [3:0]             f_bsel;

  assign f_na    = mir_q[35:27];
  assign f_jmpc  = mir_q[26];
  assign f_jamn  = mir_q[25];
  assign f_jamz  = mir_q[24];
  assign f_shift = mir_q[23:22];
  assign f_alu   = mir_q[21:16];
  assign f_csel  = mir_q[15:7];
  assign f_mem   = mir_q[6:4];
  assign f_bsel  = mir_q[3:0];

  // Jam bits OR into the address; JMPC ORs the opcode into the low byte, never adds
  assign next_mpc[MPC_BITS-1]  = f_na[MPC_BITS-1] | (f_jamn & alu_n) | (f_jamz & alu_z);
  assign next_mpc[LOW_BITS-1:0] = f_na[LOW_BITS-1:0] | (f_jmpc ? LOW_BITS'(mbr) : LOW_BITS'(0));
  assign halt_cond = (f_na == HALT_ADDR) && !f_jmpc && !f_jamn && !f_jamz;

  assign cs_addr      = mpc_q;
  assign n_flag       = n_q;
  assign z_flag       = z_q;
  assign uinstr_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      mpc_q   <= '0;
      mir_q   <= '0;
      count_q <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mir_load) mir_q <= cs_data;
      if (exec_go) begin
        n_q     <= alu_n;
        z_q     <= alu_z;
        count_q <= count_q + 32'd1;
        mpc_q   <= next_mpc;
      end
    end
  end

  // Next state and control decode; controls are only live in a non-stalled EXEC
  always_comb begin
    state_d     = state_q;
    mir_load    = 1'b0;
    exec_go     = 1'b0;
    halted      = 1'b0;
    alu_control = '0;
    shift       = '0;
    c_sel       = '0;
    mem_ctl     = '0;
    b_sel       = '0;
    case (state_q)
      ST_LOAD: begin
        mir_load = 1'b1;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (!mem_busy) begin
          exec_go     = 1'b1;
          alu_control = f_alu;
          shift       = f_shift;
          c_sel       = f_csel;
          mem_ctl     = f_mem;
          b_sel       = f_bsel;
          state_d     = halt_cond ? ST_HALT : ST_LOAD;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_mic_microsequencer.sv
// Directed bench for mic_microsequencer: table of single microinstructions with
// hand-computed next addresses, plus stall, count wrap, reset and halt sequences.
module tb_mic_microsequencer;

  logic        clk;
  logic        rst_n;
  logic [8:0]  cs_addr;
  logic [35:0] cs_data;
  logic        alu_n, alu_z;
  logic [7:0]  mbr;
  logic        mem_busy;
  logic [5:0]  alu_control;
  logic [1:0]  shift;
  logic [8:0]  c_sel;
  logic [2:0]  mem_ctl;
  logic [3:0]  b_sel;
  logic        n_flag, z_flag, halted;
  logic [31:0] uinstr_count;

  int total = 0;
  int bad   = 0;

  mic_microsequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs_addr      (cs_addr),
    .cs_data      (cs_data),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .mbr          (mbr),
    .mem_busy     (mem_busy),
    .alu_control  (alu_control),
    .shift        (shift),
    .c_sel        (c_sel),
    .mem_ctl      (mem_ctl),
    .b_sel        (b_sel),
    .n_flag       (n_flag),
    .z_flag       (z_flag),
    .halted       (halted),
    .uinstr_count (uinstr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] na;
    logic       jmpc, jamn, jamz;
    logic [1:0] sh;
    logic [5:0] alu;
    logic [8:0] csel;
    logic [2:0] mem;
    logic [3:0] bsel;
    logic       n, z;
    logic [7:0] mbr;
    logic [8:0] exp_next;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [35:0] word(input vec_t v);
    return {v.na, v.jmpc, v.jamn, v.jamz, v.sh, v.alu, v.csel, v.mem, v.bsel};
  endfunction

  function automatic logic [23:0] ctl_exp(input vec_t v);
    return {v.sh, v.alu, v.csel, v.mem, v.bsel};
  endfunction

  function automatic vec_t mkv(input logic [8:0] na, input logic jmpc, input logic jamn,
                               input logic jamz, input logic [1:0] sh, input logic [5:0] alu,
                               input logic [8:0] csel, input logic [2:0] mem,
                               input logic [3:0] bsel, input logic n, input logic z,
                               input logic [7:0] m, input logic [8:0] exp_next);
    vec_t v;
    v.na = na; v.jmpc = jmpc; v.jamn = jamn; v.jamz = jamz; v.sh = sh; v.alu = alu;
    v.csel = csel; v.mem = mem; v.bsel = bsel; v.n = n; v.z = z; v.mbr = m;
    v.exp_next = exp_next;
    return v;
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] ctl_now();
    return {shift, alu_control, c_sel, mem_ctl, b_sel};
  endfunction

  // One LOAD + EXEC pair for a microinstruction; entered and left in LOAD
  task automatic run_one(input string tag, input vec_t v, input logic [31:0] exp_cnt);
    cs_data = word(v);
    alu_n   = v.n;
    alu_z   = v.z;
    mbr     = v.mbr;
    chk({tag, " load_ctl"}, 36'(ctl_now()), 36'd0);
    tick();
    chk({tag, " exec_ctl"}, 36'(ctl_now()), 36'(ctl_exp(v)));
    tick();
    chk({tag, " next_addr"}, 36'(cs_addr), 36'(v.exp_next));
    chk({tag, " n_flag"}, 36'(n_flag), 36'(v.n));
    chk({tag, " z_flag"}, 36'(z_flag), 36'(v.z));
    chk({tag, " count"}, 36'(uinstr_count), 36'(exp_cnt));
    chk({tag, " halted"}, 36'(halted), 36'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] cnt;

    vecs[0]  = mkv(9'h005, 0, 0, 0, 2'd0, 6'h3C, 9'h001, 3'd0, 4'h0, 0, 0, 8'h00, 9'h005);
    vecs[1]  = mkv(9'h010, 0, 0, 1, 2'd1, 6'h14, 9'h002, 3'd0, 4'h1, 0, 1, 8'h00, 9'h110);
    vecs[2]  = mkv(9'h010, 0, 0, 1, 2'd2, 6'h3F, 9'h004, 3'd1, 4'h2, 0, 0, 8'h00, 9'h010);
    vecs[3]  = mkv(9'h020, 0, 1, 0, 2'd0, 6'h36, 9'h080, 3'd4, 4'h3, 1, 0, 8'h00, 9'h120);
    vecs[4]  = mkv(9'h020, 0, 1, 0, 2'd3, 6'h18, 9'h100, 3'd2, 4'h8, 0, 1, 8'h00, 9'h020);
    vecs[5]  = mkv(9'h100, 1, 0, 0, 2'd0, 6'h3C, 9'h000, 3'd1, 4'h4, 0, 0, 8'h60, 9'h160);
    vecs[6]  = mkv(9'h001, 1, 0, 0, 2'd0, 6'h35, 9'h010, 3'd0, 4'h5, 1, 0, 8'h60, 9'h061);
    vecs[7]  = mkv(9'h042, 0, 0, 0, 2'd1, 6'h2A, 9'h020, 3'd0, 4'h6, 1, 1, 8'hFF, 9'h042);
    vecs[8]  = mkv(9'h1FF, 0, 0, 1, 2'd0, 6'h3C, 9'h040, 3'd0, 4'h7, 0, 0, 8'h00, 9'h1FF);
    vecs[9]  = mkv(9'h0AA, 1, 1, 0, 2'd0, 6'h39, 9'h008, 3'd0, 4'h0, 1, 0, 8'h55, 9'h1FF);
    vecs[10] = mkv(9'h1FF, 0, 0, 1, 2'd2, 6'h10, 9'h001, 3'd4, 4'h2, 0, 1, 8'h00, 9'h1FF);

    rst_n = 1'b0; cs_data = '0; alu_n = 0; alu_z = 0; mbr = '0; mem_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst cs_addr", 36'(cs_addr), 36'd0);
    chk("rst ctl", 36'(ctl_now()), 36'd0);
    chk("rst count", 36'(uinstr_count), 36'd0);
    chk("rst flags", 36'({n_flag, z_flag, halted}), 36'd0);
    rst_n = 1'b1;

    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      cnt = cnt + 1;
      run_one($sformatf("vec%0d", i), vecs[i], cnt);
    end

    // Memory stall: three busy cycles in EXEC, then one execute cycle
    v = mkv(9'h033, 0, 0, 0, 2'd0, 6'h14, 9'h004, 3'd2, 4'h1, 0, 0, 8'h00, 9'h033);
    cs_data = word(v); alu_n = 0; alu_z = 0;
    mem_busy = 1;
    tick();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("stall%0d ctl", s), 36'(ctl_now()), 36'd0);
      chk($sformatf("stall%0d count", s), 36'(uinstr_count), 36'(cnt));
      chk($sformatf("stall%0d addr", s), 36'(cs_addr), 36'h1FF);
      if (s < 2) tick();
      else begin
        @(posedge clk); #1;
      end
    end
    mem_busy = 0;
    #0;
    chk("stall exec ctl", 36'(ctl_now()), 36'(ctl_exp(v)));
    tick();
    cnt = cnt + 1;
    chk("stall next_addr", 36'(cs_addr), 36'h033);
    chk("stall count", 36'(uinstr_count), 36'(cnt));

    // Count wrap: preset all-ones while stalled, then execute
    v = mkv(9'h044, 0, 0, 0, 2'd0, 6'h3C, 9'h001, 3'd0, 4'h0, 0, 0, 8'h00, 9'h044);
    cs_data = word(v);
    mem_busy = 1;
    tick();
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    #1;
    chk("preset count", 36'(uinstr_count), 36'hFFFF_FFFF);
    mem_busy = 0;
    tick();
    chk("wrap count", 36'(uinstr_count), 36'd0);
    chk("wrap next_addr", 36'(cs_addr), 36'h044);

    // Reset mid-stall: everything returns to reset values without a clock edge
    v = mkv(9'h055, 0, 0, 0, 2'd0, 6'h3F, 9'h010, 3'd1, 4'h3, 1, 1, 8'h00, 9'h055);
    cs_data = word(v); alu_n = 1; alu_z = 1;
    tick();
    chk("pre-rst n_flag", 36'(n_flag), 36'd0);
    mem_busy = 1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst ctl", 36'(ctl_now()), 36'd0);
    chk("midrst cs_addr", 36'(cs_addr), 36'd0);
    chk("midrst count", 36'(uinstr_count), 36'd0);
    chk("midrst flags", 36'({n_flag, z_flag, halted}), 36'd0);
    #1;
    rst_n = 1'b1;
    mem_busy = 0;
    v = mkv(9'h007, 0, 0, 0, 2'd0, 6'h3C, 9'h002, 3'd0, 4'h1, 0, 0, 8'h00, 9'h007);
    run_one("post-rst", v, 32'd1);

    // Halt: executes fully once, then freezes until reset
    v = mkv(9'h1FF, 0, 0, 0, 2'd0, 6'h35, 9'h100, 3'd0, 4'h0, 0, 1, 8'h00, 9'h1FF);
    cs_data = word(v); alu_n = 0; alu_z = 1;
    tick();
    chk("halt exec ctl", 36'(ctl_now()), 36'(ctl_exp(v)));
    chk("halt exec halted", 36'(halted), 36'd0);
    tick();
    chk("halted", 36'(halted), 36'd1);
    chk("halt count", 36'(uinstr_count), 36'd2);
    chk("halt z_flag", 36'(z_flag), 36'd1);
    chk("halt cs_addr", 36'(cs_addr), 36'h1FF);
    cs_data = 36'hF_FFFF_FFFF;
    repeat (4) tick();
    chk("frozen halted", 36'(halted), 36'd1);
    chk("frozen ctl", 36'(ctl_now()), 36'd0);
    chk("frozen count", 36'(uinstr_count), 36'd2);
    chk("frozen cs_addr", 36'(cs_addr), 36'h1FF);
    rst_n = 1'b0;
    #1;
    chk("unhalt halted", 36'(halted), 36'd0);
    chk("unhalt cs_addr", 36'(cs_addr), 36'd0);
    #1;
    rst_n = 1'b1;
    run_one("restart", vecs[3], 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
